ecall_io_ctrl: RTL

//  Sequences the single-cycle core around ECALL system services and test selection.

---
 rtl/ecall_io_ctrl_pkg.sv | 23 ++
 rtl/ecall_io_ctrl_if.sv | 27 ++
 rtl/ecall_io_ctrl_btn_debounce.sv | 53 +++++
 rtl/ecall_io_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ecall_io_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ecall_io_ctrl_pkg
//  Brief    : Shared state encoding and ECALL service numbers.
//  Revision : 1.0
// ============================================================================
package ecall_io_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT_SEL = 3'd0,
        ST_RUN      = 3'd1,
        ST_OUT_WAIT = 3'd2,
        ST_IN_WAIT  = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_READ_INT  = 32'd5;
    localparam logic [31:0] SVC_EXIT      = 32'd10;

endpackage
`default_nettype wire

// File: rtl/ecall_io_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ecall_io_ctrl_if
//  Brief    : Core-side bundle between decoder/regfile and the ECALL controller.
//  Revision : 1.0
// ============================================================================
interface ecall_io_ctrl_if;
    logic        ecall;
    logic [31:0] svc;
    logic [31:0] a0_in;
    logic        stall;
    logic        test_start;
    logic [2:0]  test_id;
    logic        a0_we;
    logic [31:0] a0_wdata;

    modport master (
        output ecall, svc, a0_in,
        input  stall, test_start, test_id, a0_we, a0_wdata
    );

    modport slave (
        input  ecall, svc, a0_in,
        output stall, test_start, test_id, a0_we, a0_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ecall_io_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Brief    : 2-FF synchronizer, stability counter and rising-edge press pulse.
//  Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 460000,
    parameter int CNT_W           = 19
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_btn,
    output logic      o_press
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // The counter only runs while the synchronized level disagrees with the
    // stable level, so any bounce back restarts the qualification window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable <= r_sync2;
                r_press  <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/ecall_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ecall_io_ctrl
//  Brief    : Sequences ECALL services and test selection against board I/O.
//  Revision : 1.0
// ============================================================================
module ecall_io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 460000,
    parameter int CNT_W           = 19
) (
    input  wire logic        clk,
    input  wire logic        reset,
    ecall_io_ctrl_if.slave   core,
    input  wire logic [7:0]  sw_in,
    input  wire logic [2:0]  test_sel,
    input  wire logic        confirm_btn,
    output logic      [31:0] disp_value,
    output logic             disp_en,
    output logic             led_need_test,
    output logic             led_need_in,
    output logic             led_halt
);
    import ecall_io_ctrl_pkg::*;

    state_t      r_state;
    logic        r_test_start;
    logic [2:0]  r_test_id;
    logic        r_a0_we;
    logic [31:0] r_a0_wdata;
    logic [31:0] r_disp_value;
    logic        r_disp_en;
    logic        r_led_need_test;
    logic        r_led_need_in;
    logic        r_led_halt;
    logic        w_press;
    logic        w_stall;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (confirm_btn),
        .o_press (w_press)
    );

    // RELEASE is the only state that lets the PC advance after a service;
    // in RUN the stall must follow ecall in the same cycle.
    always_comb begin
        w_stall = 1'b1;
        case (r_state)
            ST_RUN:     w_stall = core.ecall;
            ST_RELEASE: w_stall = 1'b0;
            default:    w_stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_BOOT_SEL;
            r_test_start    <= 1'b0;
            r_test_id       <= 3'd0;
            r_a0_we         <= 1'b0;
            r_a0_wdata      <= 32'd0;
            r_disp_value    <= 32'd0;
            r_disp_en       <= 1'b0;
            r_led_need_test <= 1'b1;
            r_led_need_in   <= 1'b0;
            r_led_halt      <= 1'b0;
        end else begin
            r_test_start <= 1'b0;
            r_a0_we      <= 1'b0;
            case (r_state)
                ST_BOOT_SEL: begin
                    if (w_press) begin
                        r_test_id       <= test_sel;
                        r_test_start    <= 1'b1;
                        r_led_need_test <= 1'b0;
                        r_state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core.ecall) begin
                        case (core.svc)
                            SVC_PRINT_INT: begin
                                r_disp_value <= core.a0_in;
                                r_disp_en    <= 1'b1;
                                r_state      <= ST_OUT_WAIT;
                            end
                            SVC_READ_INT: begin
                                r_led_need_in <= 1'b1;
                                r_state       <= ST_IN_WAIT;
                            end
                            SVC_EXIT: begin
                                r_led_halt <= 1'b1;
                                r_state    <= ST_HALT;
                            end
                            default: r_state <= ST_RELEASE;
                        endcase
                    end
                end
                ST_OUT_WAIT: begin
                    if (w_press) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_IN_WAIT: begin
                    if (w_press) begin
                        r_a0_we       <= 1'b1;
                        r_a0_wdata    <= {24'h0, sw_in};
                        r_led_need_in <= 1'b0;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: r_state <= ST_RUN;
                ST_HALT:    r_state <= ST_HALT;
                default: begin
                    r_led_need_test <= 1'b1;
                    r_led_need_in   <= 1'b0;
                    r_led_halt      <= 1'b0;
                    r_state         <= ST_BOOT_SEL;
                end
            endcase
        end
    end

    assign core.stall      = w_stall;
    assign core.test_start = r_test_start;
    assign core.test_id    = r_test_id;
    assign core.a0_we      = r_a0_we;
    assign core.a0_wdata   = r_a0_wdata;
    assign disp_value      = r_disp_value;
    assign disp_en         = r_disp_en;
    assign led_need_test   = r_led_need_test;
    assign led_need_in     = r_led_need_in;
    assign led_halt        = r_led_halt;

endmodule
`default_nettype wire
